uart_frame_parser: RTL and testbench

//  Consumes the byte stream from the UART receiver (1-cycle data/valid pulses, no backpressure).

---
 rtl/uart_frame_parser_if.sv | 39 +++
 rtl/uart_frame_parser.sv | 211 +++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_parser_if
//  Description : Byte-stream and payload-stream bundle of uart_frame_parser.
//                slave  : the parser side (consumes in_*, produces out_* and
//                         the status pulses)
//                master : the environment side (UART receiver + downstream)
//  Signals     : in_data[7:0], in_valid          receiver byte strobe
//                out_data[7:0], out_valid,
//                out_ready, out_last             payload stream
//                frame_ok, chk_err, len_err,
//                drop_err                        1-cycle status pulses
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_frame_parser_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       chk_err;
    logic       len_err;
    logic       drop_err;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_last,
        input  frame_ok, chk_err, len_err, drop_err
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_last,
        output frame_ok, chk_err, len_err, drop_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_parser
//  Description : Parses SOF/LEN/payload/CHK frames from a UART byte stream,
//                buffers the payload and releases it on a valid/ready stream
//                only after the 8-bit additive checksum (LEN+payload+CHK
//                == 0 mod 256) passes.
//  Ports       : clk            system clock
//                rst_n          asynchronous active-low reset
//                bus (slave)    in_data/in_valid byte strobe,
//                               out_data/out_valid/out_ready/out_last stream,
//                               frame_ok/chk_err/len_err/drop_err pulses
//  Options     : UART_FRAME_TIMEOUT_EN - abort a partial frame (chk_err) after
//                TIMEOUT_CYC cycles without a byte in LEN/PAY/CHK.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_frame_parser #(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF         = 8'hA5,
    parameter int         TIMEOUT_CYC = 50_000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    uart_frame_parser_if.slave bus
);

    localparam int         c_CW      = $clog2(MAX_LEN + 1);
    localparam int         c_AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] c_MAX_LEN = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT  = 3'd0,
        S_LEN   = 3'd1,
        S_PAY   = 3'd2,
        S_CHK   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            r_state, w_state_n;
    logic [7:0]        r_sum, w_sum_n;
    logic [7:0]        r_len, w_len_n;
    logic [c_CW-1:0]   r_wr, w_wr_n;
    logic [c_CW-1:0]   r_rd, w_rd_n;
    logic              r_frame_ok, w_frame_ok_n;
    logic              r_chk_err, w_chk_err_n;
    logic              r_len_err, w_len_err_n;
    logic              r_drop_err, w_drop_err_n;
    logic              w_buf_we;
    logic [7:0]        r_buf [2**c_AW];

    logic              w_out_valid;
    logic              w_out_last;
    logic              w_last_wr;
    logic [7:0]        w_chk_sum;

    // Pointers compared against the 8-bit LEN; LEN is known >= 1 here.
    assign w_last_wr   = (8'(r_wr) == (r_len - 8'd1));
    assign w_chk_sum   = r_sum + bus.in_data;
    assign w_out_valid = (r_state == S_DRAIN);
    assign w_out_last  = w_out_valid && (8'(r_rd) == (r_len - 8'd1));

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int                 c_GAP_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(TIMEOUT_CYC - 1);

    logic [c_GAP_W-1:0] r_gap, w_gap_n;
    logic               w_in_frame;

    assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAY) || (r_state == S_CHK);
`endif

    always_comb begin
        w_state_n    = r_state;
        w_sum_n      = r_sum;
        w_len_n      = r_len;
        w_wr_n       = r_wr;
        w_rd_n       = r_rd;
        w_buf_we     = 1'b0;
        w_frame_ok_n = 1'b0;
        w_chk_err_n  = 1'b0;
        w_len_err_n  = 1'b0;
        w_drop_err_n = 1'b0;

        case (r_state)
            S_HUNT: begin
                if (bus.in_valid && (bus.in_data == SOF)) begin
                    w_state_n = S_LEN;
                end
            end
            S_LEN: begin
                if (bus.in_valid) begin
                    w_sum_n = bus.in_data;
                    w_len_n = bus.in_data;
                    w_wr_n  = '0;
                    if ((bus.in_data == 8'd0) || (bus.in_data > c_MAX_LEN)) begin
                        w_len_err_n = 1'b1;
                        w_state_n   = S_HUNT;
                    end else begin
                        w_state_n = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (bus.in_valid) begin
                    w_buf_we = 1'b1;
                    w_sum_n  = w_chk_sum;
                    // Wrap wr on the final byte so it stays within the buffer.
                    if (w_last_wr) begin
                        w_wr_n    = '0;
                        w_state_n = S_CHK;
                    end else begin
                        w_wr_n = r_wr + c_CW'(1);
                    end
                end
            end
            S_CHK: begin
                if (bus.in_valid) begin
                    if (w_chk_sum == 8'h00) begin
                        w_frame_ok_n = 1'b1;
                        w_rd_n       = '0;
                        w_state_n    = S_DRAIN;
                    end else begin
                        w_chk_err_n = 1'b1;
                        w_state_n   = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                // No backpressure upstream: incoming bytes are discarded.
                if (bus.in_valid) begin
                    w_drop_err_n = 1'b1;
                end
                if (bus.out_ready) begin
                    if (w_out_last) begin
                        w_rd_n    = '0;
                        w_state_n = S_HUNT;
                    end else begin
                        w_rd_n = r_rd + c_CW'(1);
                    end
                end
            end
            default: begin
                w_state_n = S_HUNT;
            end
        endcase

`ifdef UART_FRAME_TIMEOUT_EN
        w_gap_n = '0;
        if (w_in_frame && !bus.in_valid) begin
            if (r_gap == c_GAP_MAX) begin
                w_chk_err_n = 1'b1;
                w_state_n   = S_HUNT;
            end else begin
                w_gap_n = r_gap + c_GAP_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HUNT;
            r_sum      <= 8'h00;
            r_len      <= 8'h00;
            r_wr       <= '0;
            r_rd       <= '0;
            r_frame_ok <= 1'b0;
            r_chk_err  <= 1'b0;
            r_len_err  <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_sum      <= w_sum_n;
            r_len      <= w_len_n;
            r_wr       <= w_wr_n;
            r_rd       <= w_rd_n;
            r_frame_ok <= w_frame_ok_n;
            r_chk_err  <= w_chk_err_n;
            r_len_err  <= w_len_err_n;
            r_drop_err <= w_drop_err_n;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else begin
            r_gap <= w_gap_n;
        end
    end
`endif

    // Payload storage needs no reset; contents are only read in DRAIN.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_wr[c_AW-1:0]] <= bus.in_data;
        end
    end

    // Data gated by valid so the stream reads 0 outside DRAIN and in reset.
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_buf[r_rd[c_AW-1:0]] : 8'h00;
    assign bus.out_last  = w_out_last;
    assign bus.frame_ok  = r_frame_ok;
    assign bus.chk_err   = r_chk_err;
    assign bus.len_err   = r_len_err;
    assign bus.drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_parser
//  Description : Self-checking bench for uart_frame_parser. Expected payload
//                bytes are queued when a frame is sent and compared as the
//                DUT streams them out; status pulses are counted and checked.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_frame_parser;

    logic clk = 1'b0;
    logic rst_n;

    uart_frame_parser_if u_if ();

    uart_frame_parser #(
        .MAX_LEN     (16),
        .SOF         (8'hA5),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_ok   = 0;
    int n_chk  = 0;
    int n_len  = 0;
    int n_drop = 0;

    logic [8:0] sb [$];   // {last, data}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [8:0] e;
        int         np;
        if (u_if.frame_ok) n_ok++;
        if (u_if.chk_err)  n_chk++;
        if (u_if.len_err)  n_len++;
        if (u_if.drop_err) n_drop++;
        np = int'(u_if.frame_ok) + int'(u_if.chk_err) + int'(u_if.len_err) + int'(u_if.drop_err);
        if (np > 0) begin
            checks++;
            assert (np == 1) else begin
                errors++;
                $error("FAIL pulse_exclusive: observed %0d pulses expected 1", np);
            end
        end
        if (u_if.out_valid && u_if.out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed data %0h last %0b expected no output",
                       u_if.out_data, u_if.out_last);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert ({u_if.out_last, u_if.out_data} === e) else begin
                    errors++;
                    $error("FAIL sb_byte: observed last %0b data %0h expected last %0b data %0h",
                           u_if.out_last, u_if.out_data, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        u_if.in_data  = b;
        u_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        u_if.in_data  = 8'h00;
    endtask

    function automatic logic [7:0] calc_chk(input logic [7:0] p [$]);
        logic [7:0] s;
        s = 8'(p.size());
        foreach (p[i]) s = s + p[i];
        return 8'h00 - s;
    endfunction

    // Sends a complete frame with a correct (or deliberately offset) CHK.
    task automatic send_frame(input logic [7:0] p [$], input logic [7:0] chk_offset, input bit expect_out);
        send(8'hA5);
        send(8'(p.size()));
        foreach (p[i]) send(p[i]);
        if (expect_out) begin
            foreach (p[i]) sb.push_back({(i == p.size() - 1), p[i]});
        end
        send(calc_chk(p) + chk_offset);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || u_if.out_valid) && n < 300) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, (sb.size() == 0 && !u_if.out_valid)}, 32'd1);
    endtask

    initial begin
        logic [7:0] p [$];
        int base_ok, base_drop, n;

        rst_n          = 1'b0;
        u_if.in_data   = 8'h00;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        tick(3);

        // Reset state
        check("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, u_if.out_data},  32'd0);
        check("rst_pulses", {28'd0, u_if.frame_ok, u_if.chk_err, u_if.len_err, u_if.drop_err}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: good frame A5 02 11 22 CB
        p = '{8'h11, 8'h22};
        check("t1_chk_value", {24'd0, calc_chk(p)}, 32'h0000_00CB);
        send_frame(p, 8'h00, 1'b1);
        check("t1_frame_ok_latency", {31'd0, u_if.frame_ok}, 32'd1);
        check("t1_first_valid", {31'd0, u_if.out_valid}, 32'd1);
        wait_drain("t1_drain");
        check("t1_ok_count", n_ok, 1);
        check("t1_no_errors", n_chk + n_len + n_drop, 0);

        // 2: bad checksum, then a good frame
        send_frame(p, 8'h01, 1'b0);
        check("t2_chk_err", {31'd0, u_if.chk_err}, 32'd1);
        check("t2_no_valid", {31'd0, u_if.out_valid}, 32'd0);
        tick(5);
        check("t2_chk_count", n_chk, 1);
        p = '{8'h33};
        send_frame(p, 8'h00, 1'b1);
        check("t2_recover_ok", {31'd0, u_if.frame_ok}, 32'd1);
        wait_drain("t2_drain");

        // 3: length errors and a full-buffer frame
        send(8'hA5);
        send(8'h00);
        check("t3_len_zero", {31'd0, u_if.len_err}, 32'd1);
        send(8'hA5);
        send(8'd17);
        check("t3_len_over", {31'd0, u_if.len_err}, 32'd1);
        tick(2);
        check("t3_len_count", n_len, 2);
        p.delete();
        for (int i = 0; i < 16; i++) p.push_back(8'(i * 7 + 3));
        base_ok = n_ok;
        send_frame(p, 8'h00, 1'b1);
        wait_drain("t3_full_drain");
        check("t3_full_ok", n_ok - base_ok, 1);

        // 4: backpressure with a dropped byte
        u_if.out_ready = 1'b0;
        base_drop = n_drop;
        p = '{8'h11, 8'h22};
        send_frame(p, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("t4_hold_data", {24'd0, u_if.out_data}, 32'h11);
            check("t4_hold_valid", {30'd0, u_if.out_valid, u_if.out_last}, 32'd2);
            if (i == 5) begin
                send(8'h77);
                check("t4_drop_err", {31'd0, u_if.drop_err}, 32'd1);
            end else begin
                tick(1);
            end
        end
        u_if.out_ready = 1'b1;
        wait_drain("t4_drain");
        check("t4_drop_count", n_drop - base_drop, 1);

        // 5: resync with SOF as payload
        base_ok = n_ok;
        send(8'h00);
        send(8'hFF);
        p = '{8'hA5};
        send_frame(p, 8'h00, 1'b1);
        wait_drain("t5_sof_data_drain");
        check("t5_sof_data_ok", n_ok - base_ok, 1);

        // 5: reset mid-PAY
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        rst_n = 1'b0;
        tick(2);
        check("t5_rst_pay_outs", {28'd0, u_if.out_valid, u_if.frame_ok, u_if.chk_err, u_if.len_err}, 32'd0);
        rst_n = 1'b1;
        tick(1);
        p = '{8'h5A, 8'hC3, 8'h01};
        send_frame(p, 8'h00, 1'b1);
        check("t5_rst_pay_clean", {31'd0, u_if.frame_ok}, 32'd1);
        wait_drain("t5_rst_pay_drain");

        // Reset mid-DRAIN: out_valid must fall without a clock edge
        u_if.out_ready = 1'b0;
        send_frame(p, 8'h00, 1'b1);
        check("t5_drain_valid", {31'd0, u_if.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", {31'd0, u_if.out_valid}, 32'd0);
        sb.delete();
        tick(2);
        rst_n = 1'b1;
        u_if.out_ready = 1'b1;
        tick(1);
        p = '{8'hE0, 8'h0F};
        send_frame(p, 8'h00, 1'b1);
        wait_drain("t5_rst_drain_clean");

`ifdef UART_FRAME_TIMEOUT_EN
        // 6: inter-byte timeout
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        n = 0;
        while (!u_if.chk_err && n < 150) begin
            tick(1);
            n++;
        end
        check("t6_timeout_cycles", n, 100);
        p = '{8'h44};
        send_frame(p, 8'h00, 1'b1);
        check("t6_hunt_after", {31'd0, u_if.frame_ok}, 32'd1);
        wait_drain("t6_drain");
`else
        // Without the timeout a partial frame waits for its remaining bytes.
        base_ok = n_ok;
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        tick(200);
        sb.push_back({1'b0, 8'h11});
        sb.push_back({1'b1, 8'h22});
        send(8'h22);
        send(8'hCB);
        check("t6_no_timeout_ok", {31'd0, u_if.frame_ok}, 32'd1);
        wait_drain("t6_drain");
        check("t6_ok_count", n_ok - base_ok, 1);
`endif

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
